muldiv_issue_ctrl: RTL and testbench

//  Initiator side of the multiply/divide unit (MDU) valid/ready protocol. Sits in the

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the MDU issue controller: pipeline command codes, MDU op codes and the
// issue FSM state type.
package muldiv_pkg;

  // Operand / HI / LO width; the MDU only supports 32.
  localparam int unsigned DataW = 32;

  typedef enum logic [2:0] {
    CmdNone  = 3'd0,
    CmdMult  = 3'd1,
    CmdMultu = 3'd2,
    CmdDiv   = 3'd3,
    CmdDivu  = 3'd4,
    CmdMthi  = 3'd5,
    CmdMtlo  = 3'd6,
    CmdNone7 = 3'd7
  } req_cmd_e;

  typedef enum logic [1:0] {
    OpIdle = 2'd0,
    OpMul  = 2'd1,
    OpDiv  = 2'd2
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDrain
  } state_e;

endpackage

// File: rtl/muldiv_issue_ctrl.sv
// Initiator side of the MDU valid/ready protocol, placed in the execute stage.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the pipeline, issues MUL/DIV ops to the MDU,
// owns the architectural HI/LO registers and reports busy while an MDU op is in flight.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   req_valid/ready       pipeline command handshake; req_cmd, req_src0 (rs), req_src1 (rt)
//   busy                  MDU op in flight (ISSUE/WAIT/DRAIN)
//   hi, lo                architectural HI/LO, registered
//   mdu_in_*              request channel to the MDU (valid, ready, op, sign, src0/1)
//   mdu_out_*             response channel from the MDU (valid, ready, res0=lo, res1=hi)
//   cancel                pipeline flush, present only with MULDIV_CANCEL_EN defined
//
// Build option: MULDIV_CANCEL_EN adds the cancel input and the DRAIN state, which absorbs the
// response of a cancelled in-flight op without touching HI/LO.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DataW
) (
  input  logic              clock,
  input  logic              reset,
`ifdef MULDIV_CANCEL_EN
  input  logic              cancel,
`endif
  input  logic              req_valid,
  input  logic [2:0]        req_cmd,
  input  logic [DATA_W-1:0] req_src0,
  input  logic [DATA_W-1:0] req_src1,
  output logic              req_ready,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              mdu_in_valid,
  input  logic              mdu_in_ready,
  output logic [1:0]        mdu_in_op,
  output logic              mdu_in_sign,
  output logic [DATA_W-1:0] mdu_src0,
  output logic [DATA_W-1:0] mdu_src1,
  input  logic              mdu_out_valid,
  output logic              mdu_out_ready,
  input  logic [DATA_W-1:0] mdu_res0,
  input  logic [DATA_W-1:0] mdu_res1
);

  state_e              state_q, state_d;
  mdu_op_e             op_q, op_d;
  logic                sign_q, sign_d;
  logic                in_valid_q, in_valid_d;
  logic                out_ready_q, out_ready_d;
  logic [DATA_W-1:0]   src0_q, src0_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                accept;
  req_cmd_e            cmd;

  assign cmd = req_cmd_e'(req_cmd);

`ifdef MULDIV_CANCEL_EN
  assign req_ready = (state_q == StIdle) && !cancel;
`else
  assign req_ready = (state_q == StIdle);
`endif
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != StIdle);

  assign hi            = hi_q;
  assign lo            = lo_q;
  assign mdu_in_valid  = in_valid_q;
  assign mdu_in_op     = op_q;
  assign mdu_in_sign   = sign_q;
  assign mdu_src0      = src0_q;
  assign mdu_src1      = src1_q;
  assign mdu_out_ready = out_ready_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sign_d      = sign_q;
    in_valid_d  = in_valid_q;
    out_ready_d = out_ready_q;
    src0_d      = src0_q;
    src1_d      = src1_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd)
            CmdMult, CmdMultu, CmdDiv, CmdDivu: begin
              src0_d     = req_src0;
              src1_d     = req_src1;
              op_d       = ((cmd == CmdMult) || (cmd == CmdMultu)) ? OpMul : OpDiv;
              sign_d     = (cmd == CmdMult) || (cmd == CmdDiv);
              in_valid_d = 1'b1;
              state_d    = StIssue;
            end
            CmdMthi: hi_d = req_src0;
            CmdMtlo: lo_d = req_src0;
            default: ;
          endcase
        end
      end

      StIssue: begin
`ifdef MULDIV_CANCEL_EN
        if (cancel) begin
          in_valid_d = 1'b0;
          op_d       = OpIdle;
          // If the MDU took the op this same cycle its response must still be absorbed.
          if (mdu_in_ready) begin
            out_ready_d = 1'b1;
            state_d     = StDrain;
          end else begin
            state_d = StIdle;
          end
        end else
`endif
        if (mdu_in_ready) begin
          in_valid_d  = 1'b0;
          op_d        = OpIdle;
          out_ready_d = 1'b1;
          state_d     = StWait;
        end
      end

      StWait: begin
`ifdef MULDIV_CANCEL_EN
        if (cancel) begin
          // A response consumed in the cancel cycle is simply dropped; otherwise drain it.
          if (mdu_out_valid) begin
            out_ready_d = 1'b0;
            state_d     = StIdle;
          end else begin
            state_d = StDrain;
          end
        end else
`endif
        if (mdu_out_valid) begin
          hi_d        = mdu_res1;
          lo_d        = mdu_res0;
          out_ready_d = 1'b0;
          state_d     = StIdle;
        end
      end

`ifdef MULDIV_CANCEL_EN
      StDrain: begin
        if (mdu_out_valid) begin
          out_ready_d = 1'b0;
          state_d     = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OpIdle;
      sign_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
      src0_q      <= '0;
      src1_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      in_valid_q  <= in_valid_d;
      out_ready_q <= out_ready_d;
      src0_q      <= src0_d;
      src1_q      <= src1_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl. The MDU is modelled in-bench (arithmetic on the
// request it receives); expected HI/LO come from a command-level reference model.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
`ifdef MULDIV_CANCEL_EN
  logic        cancel;
`endif
  logic        req_valid;
  logic [2:0]  req_cmd;
  logic [31:0] req_src0, req_src1;
  logic        req_ready, busy;
  logic [31:0] hi, lo;
  logic        mdu_in_valid, mdu_in_ready;
  logic [1:0]  mdu_in_op;
  logic        mdu_in_sign;
  logic [31:0] mdu_src0, mdu_src1;
  logic        mdu_out_valid, mdu_out_ready;
  logic [31:0] mdu_res0, mdu_res1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clock = ~clock;

  muldiv_issue_ctrl #(.DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef MULDIV_CANCEL_EN
    .cancel       (cancel),
`endif
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_src0     (req_src0),
    .req_src1     (req_src1),
    .req_ready    (req_ready),
    .busy         (busy),
    .hi           (hi),
    .lo           (lo),
    .mdu_in_valid (mdu_in_valid),
    .mdu_in_ready (mdu_in_ready),
    .mdu_in_op    (mdu_in_op),
    .mdu_in_sign  (mdu_in_sign),
    .mdu_src0     (mdu_src0),
    .mdu_src1     (mdu_src1),
    .mdu_out_valid(mdu_out_valid),
    .mdu_out_ready(mdu_out_ready),
    .mdu_res0     (mdu_res0),
    .mdu_res1     (mdu_res1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MDU model: acts on what it was handed (op, sign, operands). Div by zero returns
  // quotient all-ones and remainder = dividend.
  function automatic logic [63:0] mdu_model(input logic [1:0] op, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'd1) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Reference: {hi, lo} that each command must leave, derived from the command itself.
  function automatic logic [63:0] ref_result(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb;
    logic [31:0] ma, mb, q, r;
    case (c)
      CmdMult: begin
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
      end
      CmdMultu: return {32'b0, a} * {32'b0, b};
      CmdDivu:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      CmdDiv: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31])         r = -r;
        return {r, q};
      end
      default: return {hi_m, lo_m};
    endcase
  endfunction

  // Full MDU command: accept, hold ISSUE for in_dly cycles, WAIT out_dly cycles, complete.
  task automatic run_mdu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int in_dly, input int out_dly);
    logic [63:0] resp, exp;
    logic [1:0]  exp_op;
    logic        exp_sign;
    int          low_cycles;
    exp_op   = (c == CmdMult || c == CmdMultu) ? 2'd1 : 2'd2;
    exp_sign = (c == CmdMult || c == CmdDiv);
    exp      = ref_result(c, a, b);
    low_cycles = 0;
    check("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_cmd = c; req_src0 = a; req_src1 = b;
    step();
    req_valid = 1'b0; req_src0 = $urandom; req_src1 = $urandom;
    check("issue_valid", 64'(mdu_in_valid), 64'd1);
    check("issue_op", 64'(mdu_in_op), 64'(exp_op));
    check("issue_sign", 64'(mdu_in_sign), 64'(exp_sign));
    check("issue_src0", 64'(mdu_src0), 64'(a));
    check("issue_src1", 64'(mdu_src1), 64'(b));
    check("issue_busy", 64'(busy), 64'd1);
    for (int i = 0; i < in_dly; i++) begin
      if (!req_ready) low_cycles++;
      mdu_in_ready  = 1'b0;
      // Stray response while not waiting must be ignored.
      mdu_out_valid = (i == 0);
      mdu_res0 = $urandom; mdu_res1 = $urandom;
      step();
      check("hold_valid", 64'(mdu_in_valid), 64'd1);
      check("hold_srcs", {mdu_src1, mdu_src0}, {b, a});
      check("hold_op", 64'(mdu_in_op), 64'(exp_op));
      check("hold_hilo", {hi, lo}, {hi_m, lo_m});
    end
    mdu_out_valid = 1'b0;
    if (!req_ready) low_cycles++;
    resp = mdu_model(mdu_in_op, mdu_in_sign, mdu_src0, mdu_src1);
    mdu_in_ready = 1'b1;
    step();
    mdu_in_ready = 1'b0;
    check("wait_valid", 64'(mdu_in_valid), 64'd0);
    check("wait_op", 64'(mdu_in_op), 64'd0);
    check("wait_out_ready", 64'(mdu_out_ready), 64'd1);
    for (int i = 0; i < out_dly; i++) begin
      if (!req_ready) low_cycles++;
      step();
      check("wait_busy", 64'(busy), 64'd1);
    end
    if (!req_ready) low_cycles++;
    mdu_out_valid = 1'b1; mdu_res0 = resp[31:0]; mdu_res1 = resp[63:32];
    step();
    mdu_out_valid = 1'b0;
    {hi_m, lo_m} = exp;
    check("done_hilo", {hi, lo}, {hi_m, lo_m});
    check("done_ready", {62'd0, req_ready, busy}, 64'b10);
    check("done_out_ready", 64'(mdu_out_ready), 64'd0);
    check("ready_low_cycles", 64'(low_cycles), 64'(in_dly + out_dly + 2));
  endtask

  task automatic run_mt(input logic [2:0] c, input logic [31:0] a);
    req_valid = 1'b1; req_cmd = c; req_src0 = a; req_src1 = $urandom;
    step();
    req_valid = 1'b0;
    if (c == CmdMthi) hi_m = a;
    else if (c == CmdMtlo) lo_m = a;
    check("mt_hilo", {hi, lo}, {hi_m, lo_m});
    check("mt_busy", {62'd0, req_ready, busy}, 64'b10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_ctl", {58'd0, req_ready, busy, mdu_in_valid, mdu_in_op, mdu_in_sign},
          64'b100000);
    check("rst_srcs", {mdu_src1, mdu_src0}, 64'd0);
    check("rst_out_ready", 64'(mdu_out_ready), 64'd0);
  endtask

  initial begin
    int r;
    logic [31:0] a, b;
    reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_src0 = '0; req_src1 = '0;
    mdu_in_ready = 1'b0; mdu_out_valid = 1'b0; mdu_res0 = '0; mdu_res1 = '0;
`ifdef MULDIV_CANCEL_EN
    cancel = 1'b0;
`endif
    step();
    do_reset();

    // Directed arithmetic cases.
    run_mdu(CmdMult, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mdu(CmdMultu, 32'hFFFF_FFFF, 32'd2, 0, 0);
    check("t2_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_mdu(CmdDiv, 32'hFFFF_FFF9, 32'd2, 1, 4);
    check("t3_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_mdu(CmdDivu, 32'd100, 32'd7, 0, 6);
    check("t3_divu", {hi, lo}, {32'd2, 32'd14});
    run_mdu(CmdDivu, 32'h1234, 32'd0, 0, 2);
    check("divzero", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});

    // Back-to-back MTHI/MTLO, then a DIVU.
    run_mt(CmdMthi, 32'h1234_5678);
    run_mt(CmdMtlo, 32'h9ABC_DEF0);
    check("t4_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    run_mdu(CmdDivu, 32'd1000, 32'd9, 0, 3);

    // No-op commands and stray responses in IDLE leave HI/LO alone.
    req_valid = 1'b1; req_cmd = CmdNone7; req_src0 = 32'hDEAD; step();
    req_cmd = CmdNone; mdu_out_valid = 1'b1; mdu_res0 = 32'h1; mdu_res1 = 32'h2; step();
    req_valid = 1'b0; mdu_out_valid = 1'b0;
    check("nop_hilo", {hi, lo}, {hi_m, lo_m});
    check("nop_idle", {62'd0, req_ready, busy}, 64'b10);

    // Long ISSUE hold.
    run_mdu(CmdMult, 32'h8000_0000, 32'hFFFF_FFFF, 5, 1);

    // Reset while in WAIT.
    req_valid = 1'b1; req_cmd = CmdMultu; req_src0 = 32'd9; req_src1 = 32'd9; step();
    req_valid = 1'b0; mdu_in_ready = 1'b1; step();
    mdu_in_ready = 1'b0;
    check("pre_rst_wait", 64'(mdu_out_ready), 64'd1);
    do_reset();

`ifdef MULDIV_CANCEL_EN
    run_mt(CmdMthi, 32'h55);
    run_mt(CmdMtlo, 32'h55);
    // Cancel in IDLE blocks acceptance.
    cancel = 1'b1; req_valid = 1'b1; req_cmd = CmdMthi; req_src0 = 32'h77; step();
    cancel = 1'b0; req_valid = 1'b0;
    check("cancel_idle", {62'd0, busy, 1'b0} | {hi, lo}, {hi_m, lo_m});
    // Cancel in WAIT drains the result.
    req_valid = 1'b1; req_cmd = CmdDivu; req_src0 = 32'd100; req_src1 = 32'd7; step();
    req_valid = 1'b0; mdu_in_ready = 1'b1; step();
    mdu_in_ready = 1'b0; cancel = 1'b1; step();
    cancel = 1'b0;
    check("drain_busy", {62'd0, busy, mdu_out_ready}, 64'b11);
    step();
    mdu_out_valid = 1'b1; mdu_res0 = 32'd14; mdu_res1 = 32'd2; step();
    mdu_out_valid = 1'b0;
    check("drain_hilo", {hi, lo}, {32'h55, 32'h55});
    check("drain_idle", {61'd0, req_ready, busy, mdu_out_ready}, 64'b100);
    // Cancel in ISSUE before handshake returns to IDLE with nothing in flight.
    req_valid = 1'b1; req_cmd = CmdMult; req_src0 = 32'd3; req_src1 = 32'd3; step();
    req_valid = 1'b0; cancel = 1'b1; step();
    cancel = 1'b0;
    check("cancel_issue", {61'd0, req_ready, busy, mdu_in_valid}, 64'b100);
`endif

    // Randomized commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      b = ($urandom_range(0, 6) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ?
          32'($urandom_range(1, 20)) : $urandom);
      case (r)
        0, 7: run_mdu(CmdMult, a, b, $urandom_range(0, 3), $urandom_range(0, 3));
        1:    run_mdu(CmdMultu, a, b, $urandom_range(0, 3), $urandom_range(0, 3));
        2, 8: run_mdu(CmdDiv, a, b, $urandom_range(0, 3), $urandom_range(0, 8));
        3:    run_mdu(CmdDivu, a, b, $urandom_range(0, 3), $urandom_range(0, 8));
        4:    run_mt(CmdMthi, a);
        5:    run_mt(CmdMtlo, a);
        default: begin
          req_valid = 1'b1; req_cmd = (a[0]) ? CmdNone : CmdNone7; step();
          req_valid = 1'b0;
          check("rnd_nop", {hi, lo}, {hi_m, lo_m});
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
